// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and single-outstanding instruction fetch
// sequencer. Fetches one word over req/ack, buffers it for decode over
// valid/ready, and applies jr/jump/branch redirects when decode consumes it.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        id_ready,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        halted,
  output logic        addr_err
);

  typedef enum logic [1:0] {FETCH, DELIVER, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;

  // Redirect select; in DELIVER pc already holds if_pc+4, so that is the
  // fall-through target.
  always_comb begin
    target = pc;
    if (jr_en)          target = jr_target;
    else if (jump_en)   target = jump_target;
    else if (branch_en) target = branch_target;
  end

  // Fetch/deliver sequencer with registered buffer and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_pc4   <= 32'd4;
      addr_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            if_pc4   <= pc + 32'd4;
            if_valid <= 1'b1;
            pc       <= pc + 32'd4;
            state    <= DELIVER;
          end
        end
        DELIVER: begin
          if (id_ready) begin
            if_valid <= 1'b0;
            pc       <= target;
            if (target[1:0] != 2'b00) begin
              addr_err <= 1'b1;
              state    <= HALTED;
            end else if (halt) begin
              state    <= HALTED;
            end else begin
              state    <= FETCH;
            end
          end
        end
        HALTED: ;
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

endmodule
